// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state type, byte geometry and the
// helper that selects which response byte goes out next.
package spi_pkg;

    localparam int SPI_MAX_BYTES = 4;
    localparam int SPI_BYTE_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

    // Response byte idx of the loaded tx word, or 0 once past the valid count.
    function automatic logic [SPI_BYTE_W-1:0] tx_byte_sel(
        input logic [SPI_MAX_BYTES*SPI_BYTE_W-1:0] data,
        input logic [2:0]                          nvalid,
        input logic [2:0]                          idx
    );
        logic [SPI_BYTE_W-1:0] b;
        b = '0;
        if ((idx < 3'(SPI_MAX_BYTES)) && (idx < nvalid)) begin
            b = data[{idx[1:0], 3'b000} +: SPI_BYTE_W];
        end
        return b;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings one asynchronous SPI pin into clk_i and produces one-cycle rise and
// fall strobes. Macro SPI_SLAVE_DOUBLE_SYNC_EN selects a 2-flop synchroniser
// (3-cycle pin-to-strobe latency); otherwise a 1-flop synchroniser (2 cycles).
module spi_sync_edge #(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

`ifdef SPI_SLAVE_DOUBLE_SYNC_EN
    logic meta_q, meta_d;
`endif
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next values for the synchroniser chain and the edge-detect history flop.
    always_comb begin
`ifdef SPI_SLAVE_DOUBLE_SYNC_EN
        meta_d = async_i;
        sync_d = meta_q;
`else
        sync_d = async_i;
`endif
        prev_d = sync_q;
    end

    // Chain registers; reset to the idle line level so no false edge appears.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
`ifdef SPI_SLAVE_DOUBLE_SYNC_EN
            meta_q <= IDLE_VAL;
`endif
            sync_q <= IDLE_VAL;
            prev_q <= IDLE_VAL;
        end else begin
`ifdef SPI_SLAVE_DOUBLE_SYNC_EN
            meta_q <= meta_d;
`endif
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled on clk_i. Receives up to MAX_BYTES bytes
// into rx_data_o and returns up to MAX_BYTES preloaded response bytes.
// Build option: SPI_SLAVE_DOUBLE_SYNC_EN selects 2-flop input synchronisers.
module spi_slave
    import spi_pkg::*;
#(
    parameter int MAX_BYTES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spi_clk_i,
    input  logic        spi_ss_i,
    input  logic        spi_mosi_i,
    output logic        spi_miso_o,
    input  logic [31:0] tx_data_i,
    input  logic [2:0]  tx_bytes_valid_i,
    input  logic        tx_load_i,
    output logic        tx_ready_o,
    output logic [31:0] rx_data_o,
    output logic [2:0]  rx_bytes_valid_o,
    output logic        rx_valid_o
);

    localparam logic [2:0] MAX_B = 3'(MAX_BYTES);
    localparam int         WORD_W = SPI_MAX_BYTES * SPI_BYTE_W;

    logic ss_sync, ss_rise, ss_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic mosi_sync, mosi_rise, mosi_fall;
    logic unused_sync;

    spi_sync_edge #(.IDLE_VAL(1'b1)) u_sync_ss (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(spi_ss_i),
        .sync_o (ss_sync),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_sclk (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(spi_clk_i),
        .sync_o (sclk_sync),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_mosi (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .async_i(spi_mosi_i),
        .sync_o (mosi_sync),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    assign unused_sync = ^{ss_sync, sclk_sync, mosi_rise, mosi_fall};

    spi_state_e                state_q, state_d;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [2:0]                byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]         rx_data_q, rx_data_d;
    logic [2:0]                tx_bytes_q, tx_bytes_d;
    logic                      miso_q, miso_d;
    logic [WORD_W-1:0]         tx_data_q, tx_data_d;
    logic [SPI_BYTE_W-1:0]     tx_sr_q, tx_sr_d;
    logic [SPI_BYTE_W-1:0]     rx_sr_q, rx_sr_d;

    // Next-state logic: transaction FSM, shift registers, counters and MISO.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rx_data_d  = rx_data_q;
        tx_bytes_d = tx_bytes_q;
        miso_d     = miso_q;
        tx_data_d  = tx_data_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;

        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (tx_load_i) begin
                    tx_data_d  = tx_data_i;
                    tx_bytes_d = tx_bytes_valid_i;
                end
                if (ss_fall) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    rx_data_d  = '0;
                    // First response bit must be on the wire before the first rise.
                    tx_sr_d    = tx_byte_sel(tx_data_d, tx_bytes_d, 3'd0);
                    miso_d     = tx_sr_d[SPI_BYTE_W-1];
                end
            end

            SHIFT: begin
                if (sclk_rise) begin
                    rx_sr_d   = {rx_sr_q[SPI_BYTE_W-2:0], mosi_sync};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if ((bit_cnt_q == 3'd7) && (byte_cnt_q < MAX_B)) begin
                        rx_data_d[{byte_cnt_q[1:0], 3'b000} +: SPI_BYTE_W] = rx_sr_d;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
                if (sclk_fall) begin
                    // A fall with bit count 0 closes a byte; byte_cnt already names the next one.
                    if (bit_cnt_q == 3'd0) begin
                        tx_sr_d = tx_byte_sel(tx_data_q, tx_bytes_q, byte_cnt_q);
                    end else begin
                        tx_sr_d = {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
                    end
                    miso_d = tx_sr_d[SPI_BYTE_W-1];
                end
                // Evaluated after the clock rise so a coincident last bit still counts.
                if (ss_rise) begin
                    state_d = DONE;
                    miso_d  = 1'b0;
                end
            end

            DONE: begin
                state_d    = IDLE;
                tx_bytes_d = '0;
                miso_d     = 1'b0;
            end

            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    // Control and visible-output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            rx_data_q  <= '0;
            tx_bytes_q <= '0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rx_data_q  <= rx_data_d;
            tx_bytes_q <= tx_bytes_d;
            miso_q     <= miso_d;
        end
    end

    // Datapath registers; only read after being written in a transaction.
    always_ff @(posedge clk_i) begin
        tx_data_q <= tx_data_d;
        tx_sr_q   <= tx_sr_d;
        rx_sr_q   <= rx_sr_d;
    end

    assign spi_miso_o       = miso_q;
    assign tx_ready_o       = (state_q == IDLE);
    assign rx_data_o        = rx_data_q;
    assign rx_bytes_valid_o = byte_cnt_q;
    assign rx_valid_o       = (state_q == DONE);

endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave with a transaction-level reference model.
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, ss, mosi, miso;
    logic [31:0] txd;
    logic [2:0]  txv;
    logic        txl;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic [2:0]  rx_bytes;
    logic        rx_valid;

    always #5 clk = ~clk;

    spi_slave #(.MAX_BYTES(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .spi_clk_i       (sclk),
        .spi_ss_i        (ss),
        .spi_mosi_i      (mosi),
        .spi_miso_o      (miso),
        .tx_data_i       (txd),
        .tx_bytes_valid_i(txv),
        .tx_load_i       (txl),
        .tx_ready_o      (tx_ready),
        .rx_data_o       (rx_data),
        .rx_bytes_valid_o(rx_bytes),
        .rx_valid_o      (rx_valid)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0] m_txd = '0;
    int          m_txv = 0;
    logic [31:0] exp_rx = '0;
    int          exp_cnt = 0;
    bit          expect_pulse = 0;
    int          pulses = 0;
    int          ss_hi = 0;
    logic [7:0]  cap [0:5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Compare process: rx result on every valid pulse, quiet-bus outputs when idle.
    always @(negedge clk) begin
        if (rx_valid) begin
            pulses++;
            chk("rx_valid_allowed", 32'(expect_pulse), 32'd1);
            chk("rx_data_at_valid", rx_data, exp_rx);
            chk("rx_bytes_at_valid", 32'(rx_bytes), 32'(exp_cnt));
        end
        if (ss && !rst) ss_hi++;
        else ss_hi = 0;
        if (ss_hi >= 6) begin
            chk("idle_miso", 32'(miso), 32'd0);
            chk("idle_ready", 32'(tx_ready), 32'd1);
            chk("idle_valid", 32'(rx_valid), 32'd0);
        end
    end

    task automatic run_txn(input logic [31:0] d, input int v, input bit load, input int nbits,
                           input logic [47:0] mb, input bit mid_load, input int half);
        int nfull, bi;
        logic [7:0] cur, exp_b;
        if (load) begin
            chk("ready_before_load", 32'(tx_ready), 32'd1);
            txd = d;
            txv = 3'(v);
            txl = 1'b1;
            @(negedge clk);
            txl = 1'b0;
            m_txd = d;
            m_txv = v;
        end
        nfull = nbits / 8;
        if (nfull > 4) nfull = 4;
        exp_rx = '0;
        for (int i = 0; i < nfull; i++) exp_rx[8*i +: 8] = mb[8*i +: 8];
        exp_cnt = nfull;
        expect_pulse = 1;
        pulses = 0;
        cur = '0;
        ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < nbits; k++) begin
            bi = k / 8;
            mosi = mb[8*bi + 7 - (k % 8)];
            repeat (half) @(negedge clk);
            cur = {cur[6:0], miso};
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
            if ((k % 8) == 7) begin
                cap[bi] = cur;
                exp_b = (bi < m_txv && bi < 4) ? m_txd[8*bi +: 8] : 8'h00;
                chk($sformatf("miso_byte%0d", bi), 32'(cur), 32'(exp_b));
            end
            if (mid_load && k == 3) begin
                chk("ready_in_shift", 32'(tx_ready), 32'd0);
                txd = 32'hFFFF_FFFF;
                txv = 3'd4;
                txl = 1'b1;
                @(negedge clk);
                txl = 1'b0;
            end
        end
        repeat (half) @(negedge clk);
        ss = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
        chk("pulse_count", 32'(pulses), 32'd1);
        chk("rx_data_held", rx_data, exp_rx);
        chk("rx_bytes_held", 32'(rx_bytes), 32'(exp_cnt));
        m_txv = 0;
        expect_pulse = 0;
    endtask

    initial begin
        logic [63:0] r64;
        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        txd = '0; txv = '0; txl = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd1);
        chk("rst_rx_data", rx_data, 32'd0);
        chk("rst_rx_bytes", 32'(rx_bytes), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Four-byte exchange
        run_txn(32'hA1B2C3D4, 4, 1, 32, 48'h0000_4433_2211, 0, 5);
        chk("a_miso0", 32'(cap[0]), 32'h0000_00D4);
        chk("a_miso1", 32'(cap[1]), 32'h0000_00C3);
        chk("a_miso2", 32'(cap[2]), 32'h0000_00B2);
        chk("a_miso3", 32'(cap[3]), 32'h0000_00A1);
        chk("a_rx_data", rx_data, 32'h4433_2211);
        chk("a_rx_bytes", 32'(rx_bytes), 32'd4);

        // One valid response byte, three bytes clocked
        run_txn(32'h0000_005A, 1, 1, 24, 48'h0000_0077_6655, 0, 4);
        chk("b_miso0", 32'(cap[0]), 32'h0000_005A);
        chk("b_miso1", 32'(cap[1]), 32'h0000_0000);
        chk("b_miso2", 32'(cap[2]), 32'h0000_0000);
        chk("b_rx_bytes", 32'(rx_bytes), 32'd3);

        // 13 bits: partial second byte dropped
        run_txn(32'h0, 0, 0, 13, 48'h0000_0000_B8F0, 0, 6);
        chk("c_rx_data", rx_data, 32'h0000_00F0);
        chk("c_rx_bytes", 32'(rx_bytes), 32'd1);

        // Six bytes: saturation at four
        run_txn(32'h0102_0304, 4, 1, 48, 48'h6655_4433_2211, 0, 4);
        chk("d_miso4", 32'(cap[4]), 32'h0000_0000);
        chk("d_miso5", 32'(cap[5]), 32'h0000_0000);
        chk("d_rx_data", rx_data, 32'h4433_2211);
        chk("d_rx_bytes", 32'(rx_bytes), 32'd4);

        // Reset in the middle of a transaction
        txd = 32'h1234_5678; txv = 3'd4; txl = 1'b1;
        @(negedge clk);
        txl = 1'b0;
        pulses = 0;
        expect_pulse = 0;
        ss = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            mosi = k[0];
            repeat (5) @(negedge clk);
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        chk("e_bytes_before_rst", 32'(rx_bytes), 32'd1);
        rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        @(negedge clk);
        chk("e_rst_miso", 32'(miso), 32'd0);
        chk("e_rst_ready", 32'(tx_ready), 32'd1);
        chk("e_rst_rx_data", rx_data, 32'd0);
        chk("e_rst_rx_bytes", 32'(rx_bytes), 32'd0);
        chk("e_rst_rx_valid", 32'(rx_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("e_no_pulse", 32'(pulses), 32'd0);
        m_txv = 0;
        run_txn(32'h0, 0, 0, 16, 48'h0000_0000_C33C, 0, 5);

        // Load attempted during SHIFT is ignored
        run_txn(32'h0, 0, 0, 24, 48'h0000_0099_8877, 1, 5);
        run_txn(32'h0, 0, 0, 16, 48'h0000_0000_5AA5, 0, 5);
        chk("f_miso0", 32'(cap[0]), 32'h0000_0000);
        chk("f_miso1", 32'(cap[1]), 32'h0000_0000);

        // Randomised transactions
        for (int t = 0; t < 10; t++) begin
            r64 = {$urandom, $urandom};
            run_txn($urandom, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 48)), r64[47:0], 0, int'($urandom_range(4, 6)));
        end

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 4, meaning the maximum bytes per transaction; the only legal value is 4.
REQ-002 SHALL have port clk_i, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, synchronous to clk_i and active-high.
REQ-004 SHALL have port spi_clk_i, input, 1 bit: SPI clock from the master, asynchronous to clk_i, SPI mode 0 (CPOL=0, CPHA=0).
REQ-005 SHALL have port spi_ss_i, input, 1 bit: slave select, active-low, asynchronous.
REQ-006 SHALL have port spi_mosi_i, input, 1 bit: master-out serial data, MSB first.
REQ-007 SHALL have port spi_miso_o, output, 1 bit: slave-out serial data, MSB first; driven 0 when not selected.
REQ-008 SHALL have port tx_data_i, input, 32 bits: response bytes; byte 0 is in [7:0] and is sent first.
REQ-009 SHALL have port tx_bytes_valid_i, input, 3 bits: number of valid response bytes (0..4).
REQ-010 SHALL have port tx_load_i, input, 1 bit: loads tx_data_i and tx_bytes_valid_i when tx_ready_o=1.
REQ-011 SHALL have port tx_ready_o, output, 1 bit: high only in IDLE.
REQ-012 SHALL have port rx_data_o, output, 32 bits: received bytes; first byte is in [7:0].
REQ-013 SHALL have port rx_bytes_valid_o, output, 3 bits: count of complete bytes received (0..4).
REQ-014 SHALL have port rx_valid_o, output, 1 bit: one-cycle pulse marking rx_data_o and rx_bytes_valid_o valid.

Function
REQ-015 SHALL synchronise spi_clk_i, spi_ss_i and spi_mosi_i into clk_i before use, and SHALL derive one-cycle rise and fall strobes for the synchronised spi_clk and spi_ss.
REQ-016 SHALL implement exactly three states:
  - IDLE to SHIFT on an ss fall strobe;
  - SHIFT to DONE on an ss rise strobe;
  - DONE to IDLE unconditionally after one cycle.
REQ-017 SHALL, on the ss fall strobe, load the tx shift register with tx byte 0 and drive its MSB on spi_miso_o in the same cycle.
REQ-018 SHALL, in SHIFT, sample synchronised MOSI into the rx shift register on each spi_clk rise strobe.
REQ-019 SHALL, in SHIFT, advance spi_miso_o to the next bit on each spi_clk fall strobe.
REQ-020 SHALL keep a 3-bit bit counter; on the 8th rise, the completed byte SHALL be written to rx_data_o lane [8*n+7:8*n], where n is the byte count, and n SHALL then increment.
REQ-021 SHALL, after the 8th fall of byte n, load tx byte n+1 when n+1 < loaded tx_bytes_valid, and 8'h00 otherwise.
REQ-022 SHALL, once n=4, saturate the byte count, ignore further MOSI bits (rx_data_o unchanged) and drive spi_miso_o 0.
REQ-023 SHALL, in DONE, pulse rx_valid_o for exactly one cycle with rx_bytes_valid_o = n; a partial byte SHALL be discarded.
REQ-024 SHALL hold rx_data_o and rx_bytes_valid_o until the next ss fall strobe, which SHALL clear both to 0.
REQ-025 SHALL treat the loaded tx data as consumed in DONE, setting tx_bytes_valid to 0; an unloaded transaction SHALL send all zeros.
REQ-026 SHALL ignore tx_load_i when tx_ready_o=0.
REQ-027 SHALL ignore spi_clk strobes in IDLE and DONE.
REQ-028 SHALL, if ss rise and spi_clk rise strobes occur in the same cycle, apply the clock rise first and then enter DONE.
REQ-029 SHALL operate correctly for spi_clk_i period ≥ 8 clk_i periods.

Reset
REQ-030 SHALL, with rst_i=1 at a clk_i edge, force:
  - state IDLE;
  - spi_miso_o=0, tx_ready_o=1, rx_data_o=0, rx_bytes_valid_o=0, rx_valid_o=0;
  - bit and byte counters 0, loaded tx_bytes_valid 0;
  - synchroniser flops to the idle line levels: ss=1, clk=0.
REQ-031 SHALL, on reset during SHIFT, abort the transaction with no rx_valid_o pulse.

Configuration
REQ-032 SHALL, when macro SPI_SLAVE_DOUBLE_SYNC_EN is defined, use a 2-flop synchroniser per SPI input, giving pin-to-strobe latency of 3 clk_i cycles.
REQ-033 SHALL, when SPI_SLAVE_DOUBLE_SYNC_EN is undefined, use a 1-flop synchroniser, giving latency of 2 cycles; all other behaviour SHALL be identical.

Structure
REQ-034 SHALL take the state enum typedef (IDLE, SHIFT, DONE), SPI_MAX_BYTES=4 and SPI_BYTE_W=8 from shared package spi_pkg.
REQ-035 SHALL place synchronisation and edge detection in one sub-module, spi_sync_edge, instantiated once per SPI input.

Verification
REQ-036 SHALL cover: load tx 32'hA1B2C3D4, 4 valid bytes, with master sending 4 bytes 8'h11, 8'h22, 8'h33, 8'h44 -> MISO bytes 8'hD4, 8'hC3, 8'hB2, 8'hA1; rx_data_o=32'h44332211; rx_bytes_valid_o=4; one rx_valid_o pulse.
REQ-037 SHALL cover: tx_bytes_valid=1 (8'h5A) with master clocking 3 bytes -> MISO bytes 8'h5A, 8'h00, 8'h00; rx_bytes_valid_o=3.
REQ-038 SHALL cover: master clocks 13 bits (8'hF0 then 5 bits) -> rx_bytes_valid_o=1, rx_data_o=32'h000000F0.
REQ-039 SHALL cover: master clocks 6 bytes -> rx_bytes_valid_o=4; bytes 5-6 ignored; MISO 0 for bytes 5-6.
REQ-040 SHALL cover: rst_i asserted after 10 bits -> no rx_valid_o pulse; all outputs at reset values; the next transaction is correct.
REQ-041 SHALL cover: tx_load_i during SHIFT with 32'hFFFFFFFF -> ignored; the following transaction sends zeros.
